// File: rtl/rx_pipe.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Framing errors and overruns latch a sticky error flag until reset.
module rx_pipe #(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUD     = 9_600,
   parameter int DEPTH    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       pop_front,
   output logic [7:0] data_out,
   output logic       empty,
   output logic       full,
   output logic       error
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             rx_p0;
   logic             rx_p1;
   logic             rx_s;
   logic             expire;
   logic             can_accept;
   logic             push;
   logic             pop_ok;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   // Synchronizer stage boundary: two flops, idle-high after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
      end
   end

   assign rx_s       = rx_p1;
   assign expire     = (cnt == '0);
   assign can_accept = !full || pop_front;
   assign push       = (state == STOP) && expire && rx_s && can_accept;
   assign pop_ok     = pop_front && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         error   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  cnt   <= HALF_LOAD;
                  state <= START;
               end
            end
            START: begin
               if (!expire) begin
                  cnt <= cnt - CNT_ONE;
               end else if (rx_s) begin
                  state <= IDLE;
               end else begin
                  cnt     <= FULL_LOAD;
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (!expire) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  cnt     <= FULL_LOAD;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (!expire) begin
                  cnt <= cnt - CNT_ONE;
               end else if (rx_s) begin
                  if (!can_accept) error <= 1'b1;
                  state <= IDLE;
               end else begin
                  error <= 1'b1;
                  state <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Shift register holds data only, so it carries no reset
   always_ff @(posedge clk) begin
      if (state == DATA && expire) shreg <= {rx_s, shreg[7:1]};
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop_ok})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign empty = (count == '0);
   assign full  = (count == COUNT_MAX);
   // Head forced to zero while empty so the output is defined without clearing storage
   assign data_out = empty ? 8'h00 : mem[rd_ptr];

endmodule
